// File: rtl/msrv32_store_unit.sv
// msrv32_store_unit: data-bus write master for RV32I stores.
// Turns a decoder store request into a two-phase AHB-style write
// (address phase, then data phase) with byte lanes and a write mask,
// and holds the pipeline until the data phase completes.
//
// Ports:
//   ms_riscv32_mp_clk_in  clock
//   ms_riscv32_mp_rst_in  synchronous active-high reset
//   mem_wr_req_in         store request (already gated upstream)
//   funct3_in             store size in [1:0]: 00 byte, 01 half, else word
//   iadder_in             effective byte address
//   rs2_in                store data
//   ahb_ready_in          bus ready (HREADY)
//   ahb_resp_in           bus error response (HRESP)
//   d_addr_out            word-aligned address
//   data_out              lane-replicated write data
//   wr_mask_out           byte-enable mask
//   wr_req_out            write request, address phase
//   ahb_htrans_out        NONSEQ (10) in address phase, IDLE (00) otherwise
//   stall_out             pipeline hold
//   store_fault_out       store access fault pulse
//
// Optional feature macro: MSRV32_STORE_ERR_EN
//   Defined:   an error response that completes the data phase raises
//              store_fault_out for one cycle.
//   Undefined: ahb_resp_in is ignored, store_fault_out is tied 0.

module msrv32_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    input  logic              mem_wr_req_in,
    input  logic [2:0]        funct3_in,
    input  logic [ADDR_W-1:0] iadder_in,
    input  logic [DATA_W-1:0] rs2_in,
    input  logic              ahb_ready_in,
    input  logic              ahb_resp_in,
    output logic [ADDR_W-1:0] d_addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        wr_mask_out,
    output logic              wr_req_out,
    output logic [1:0]        ahb_htrans_out,
    output logic              stall_out,
    output logic              store_fault_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_t;

    state_t state;

    logic [DATA_W-1:0] lane_data;
    logic [3:0]        lane_mask;

    // Replicate the store data across all lanes so the slave can pick
    // whichever lanes the mask enables.
    always_comb begin
        lane_data = rs2_in;
        lane_mask = 4'b1111;
        case (funct3_in[1:0])
            2'b00: begin
                lane_data = {4{rs2_in[7:0]}};
                lane_mask = 4'b0001 << iadder_in[1:0];
            end
            2'b01: begin
                lane_data = {2{rs2_in[15:0]}};
                lane_mask = iadder_in[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_data = rs2_in;
                lane_mask = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state          <= IDLE;
            d_addr_out     <= '0;
            data_out       <= '0;
            wr_mask_out    <= '0;
            wr_req_out     <= 1'b0;
            ahb_htrans_out <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_wr_req_in) begin
                        d_addr_out     <= {iadder_in[ADDR_W-1:2], 2'b00};
                        data_out       <= lane_data;
                        wr_mask_out    <= lane_mask;
                        wr_req_out     <= 1'b1;
                        ahb_htrans_out <= 2'b10;
                        state          <= ADDR;
                    end
                end
                ADDR: begin
                    if (ahb_ready_in) begin
                        wr_req_out     <= 1'b0;
                        ahb_htrans_out <= 2'b00;
                        state          <= DATA;
                    end
                end
                DATA: begin
                    if (ahb_ready_in) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    wr_req_out     <= 1'b0;
                    ahb_htrans_out <= 2'b00;
                    state          <= IDLE;
                end
            endcase
        end
    end

    // Drops in the cycle the data phase completes so the decoder can
    // present the next store one cycle later.
    assign stall_out = ((state == IDLE) & mem_wr_req_in)
                     | (state == ADDR)
                     | ((state == DATA) & ~ahb_ready_in);

`ifdef MSRV32_STORE_ERR_EN
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            store_fault_out <= 1'b0;
        end else begin
            store_fault_out <= (state == DATA) & ahb_ready_in & ahb_resp_in;
        end
    end
`else
    logic unused_resp;
    assign unused_resp     = ahb_resp_in;
    assign store_fault_out = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Testbench for msrv32_store_unit.
// Directed stores with a scoreboard-checked bus monitor.

module tb_msrv32_store_unit;

    logic        clk;
    logic        rst;
    logic        mem_wr_req_in;
    logic [2:0]  funct3_in;
    logic [31:0] iadder_in;
    logic [31:0] rs2_in;
    logic        ahb_ready_in;
    logic        ahb_resp_in;
    logic [31:0] d_addr_out;
    logic [31:0] data_out;
    logic [3:0]  wr_mask_out;
    logic        wr_req_out;
    logic [1:0]  ahb_htrans_out;
    logic        stall_out;
    logic        store_fault_out;

    msrv32_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .mem_wr_req_in        (mem_wr_req_in),
        .funct3_in            (funct3_in),
        .iadder_in            (iadder_in),
        .rs2_in               (rs2_in),
        .ahb_ready_in         (ahb_ready_in),
        .ahb_resp_in          (ahb_resp_in),
        .d_addr_out           (d_addr_out),
        .data_out             (data_out),
        .wr_mask_out          (wr_mask_out),
        .wr_req_out           (wr_req_out),
        .ahb_htrans_out       (ahb_htrans_out),
        .stall_out            (stall_out),
        .store_fault_out      (store_fault_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    logic        dphase = 1'b0;
    logic [31:0] dexp   = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    // Bus monitor: checks each accepted address phase and each
    // completed data phase against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            dphase <= 1'b0;
        end else begin
            if (dphase && ahb_ready_in) begin
                chk("data_out", data_out, dexp);
                dphase <= 1'b0;
            end
            if (wr_req_out && ahb_ready_in) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_addr_phase", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("d_addr_out", d_addr_out, e.addr);
                    chk("wr_mask_out", {28'd0, wr_mask_out}, {28'd0, e.mask});
                    chk("htrans_addr", {30'd0, ahb_htrans_out}, 32'd2);
                    dexp   <= e.data;
                    dphase <= 1'b1;
                end
            end
        end
    end

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] em,
                            input logic [31:0] ed, input int aw,
                            input int dw, input logic resp);
        exp_t e;
        int   ph;
        int   n;
        int   st;
        int   wa;
        int   wd;
        logic rdy;
        bit   done;
        e.addr = {a[31:2], 2'b00};
        e.mask = em;
        e.data = ed;
        exp_q.push_back(e);
        mem_wr_req_in = 1'b1;
        funct3_in     = f3;
        iadder_in     = a;
        rs2_in        = d;
        ph   = 0;
        n    = 0;
        st   = 0;
        wa   = aw;
        wd   = dw;
        done = 0;
        while (!done) begin
            if (n >= 40) begin
                chk("store_timeout", 32'd1, 32'd0);
                break;
            end
            case (ph)
                0:       rdy = 1'b1;
                1:       rdy = (wa == 0);
                default: rdy = (wd == 0);
            endcase
            ahb_ready_in = rdy;
            ahb_resp_in  = (ph == 2) && rdy && resp;
            @(negedge clk);
            if (stall_out) st++;
            if (ph == 0) begin
                chk("idle_wr_req", {31'd0, wr_req_out}, 32'd0);
            end
            if (ph == 1 && !rdy) begin
                chk("wait_addr_hold", d_addr_out, e.addr);
                chk("wait_wr_req", {31'd0, wr_req_out}, 32'd1);
            end
            if (ph == 2 && !rdy) begin
                chk("wait_data_hold", data_out, ed);
            end
            @(posedge clk);
            #1;
            n++;
            case (ph)
                0: ph = 1;
                1: if (rdy) ph = 2; else wa--;
                default: if (rdy) done = 1; else wd--;
            endcase
        end
        mem_wr_req_in = 1'b0;
        ahb_ready_in  = 1'b1;
        ahb_resp_in   = 1'b0;
        chk("stall_cycles", st, 2 + aw + dw);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_wr_req"}, {31'd0, wr_req_out}, 32'd0);
        chk({tag, "_htrans"}, {30'd0, ahb_htrans_out}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall_out}, 32'd0);
        chk({tag, "_addr"}, d_addr_out, 32'd0);
        chk({tag, "_data"}, data_out, 32'd0);
        chk({tag, "_mask"}, {28'd0, wr_mask_out}, 32'd0);
        chk({tag, "_fault"}, {31'd0, store_fault_out}, 32'd0);
    endtask

    logic exp_fault;

    initial begin
`ifdef MSRV32_STORE_ERR_EN
        exp_fault = 1'b1;
`else
        exp_fault = 1'b0;
`endif
        rst           = 1'b1;
        mem_wr_req_in = 1'b0;
        funct3_in     = 3'b000;
        iadder_in     = '0;
        rs2_in        = '0;
        ahb_ready_in  = 1'b1;
        ahb_resp_in   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_state("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset in the middle of an address phase abandons the transfer.
        mem_wr_req_in = 1'b1;
        funct3_in     = 3'b010;
        iadder_in     = 32'h0000_4000;
        rs2_in        = 32'h1111_2222;
        ahb_ready_in  = 1'b0;
        @(posedge clk);
        #1;
        mem_wr_req_in = 1'b0;
        @(negedge clk);
        chk("pre_rst_wr_req", {31'd0, wr_req_out}, 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("mid_rst");
        @(posedge clk);
        #1;
        ahb_ready_in = 1'b1;

        // SB at byte 3
        do_store(3'b000, 32'h0000_1003, 32'h0000_00A5,
                 4'b1000, 32'hA5A5_A5A5, 0, 0, 1'b0);
        // SB at byte 1
        do_store(3'b000, 32'h0000_1001, 32'h0000_003C,
                 4'b0010, 32'h3C3C_3C3C, 0, 0, 1'b0);
        // SH upper half
        do_store(3'b001, 32'h0000_2002, 32'h1234_BEEF,
                 4'b1100, 32'hBEEF_BEEF, 0, 0, 1'b0);
        // SH lower half, addr[0] ignored
        do_store(3'b001, 32'h0000_2005, 32'h1234_5678,
                 4'b0011, 32'h5678_5678, 0, 0, 1'b0);
        // SW with wait states
        do_store(3'b010, 32'h0000_3000, 32'hDEAD_BEEF,
                 4'b1111, 32'hDEAD_BEEF, 2, 1, 1'b0);
        // Back-to-back SW then SB (funct3=011 treated as word)
        do_store(3'b011, 32'h0000_5004, 32'hCAFE_F00D,
                 4'b1111, 32'hCAFE_F00D, 0, 0, 1'b0);
        do_store(3'b000, 32'h0000_5006, 32'h0000_0077,
                 4'b0100, 32'h7777_7777, 0, 0, 1'b0);

        // Error response on data phase
        @(negedge clk);
        chk("fault_before", {31'd0, store_fault_out}, 32'd0);
        @(posedge clk);
        #1;
        do_store(3'b010, 32'h0000_6000, 32'h0BAD_0BAD,
                 4'b1111, 32'h0BAD_0BAD, 0, 0, 1'b1);
        @(negedge clk);
        chk("fault_pulse", {31'd0, store_fault_out}, {31'd0, exp_fault});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("fault_clear", {31'd0, store_fault_out}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("end_stall", {31'd0, stall_out}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
